// File: rtl/normalizer_pkg.sv
// Shared types and constants for the normalizer/quantizer: FSM encoding,
// Q16.16 reference values and datapath widths.
package normalizer_pkg;

    localparam int MAG_W  = 32;
    localparam int Q_W    = 8;
    localparam int ADDR_W = 10;
    localparam int LANES  = 2;

    localparam logic [MAG_W-1:0] Q16_ONE = 32'h0001_0000;
    localparam logic [Q_W-1:0]   Q_MAX   = 8'd127;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_IN = 3'd1,
        ST_CONVERT = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Counter add that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/normalizer_quant_lane.sv
// One quantizer lane: Q16.16 magnitude plus sign flag -> symmetric Q1.7 value
// with a flag raised whenever the magnitude had to be limited.
module normalizer_quant_lane
    import normalizer_pkg::*;
(
    input  logic [MAG_W-1:0] mag,
    input  logic             neg,
    output logic [Q_W-1:0]   q_out,
    output logic             sat
);

    logic [Q_W-1:0] rounded;
    logic [Q_W-1:0] q_mag;

    always_comb begin
        // Keep 7 fraction bits, round half up using the first dropped bit.
        rounded = {1'b0, mag[15:9]} + {7'd0, mag[8]};
        q_mag   = rounded;
        sat     = 1'b0;
        if (mag >= Q16_ONE) begin
            q_mag = Q_MAX;
            sat   = 1'b1;
        end else if (rounded > Q_MAX) begin
            q_mag = Q_MAX;
            sat   = 1'b1;
        end
        // Magnitude never exceeds 127, so negation cannot produce 0x80; -0 stays 0.
        q_out = neg ? (~q_mag + 8'd1) : q_mag;
    end

endmodule

// File: rtl/normalizer_quantizer.sv
// Frame-based quantizer: accepts magnitude pairs, converts each to two Q1.7
// bytes and writes them to memory at the pair index, counting saturations.
module normalizer_quantizer
    import normalizer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] frame_len,
    input  logic [MAG_W-1:0]  sspect_data_1,
    input  logic [MAG_W-1:0]  sspect_data_2,
    input  logic              sspect_minus_1,
    input  logic              sspect_minus_2,
    input  logic              sspect_valid,
    output logic              sspect_rdy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              mem_wr,
    input  logic              mem_busy,
    output logic              frame_done,
    output logic [7:0]        sat_count,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] frame_len_q, frame_len_d;
    logic [ADDR_W-1:0] pair_cnt_q, pair_cnt_d;
    logic [7:0]        sat_count_q, sat_count_d;
    logic [15:0]       data_q, data_d;
    logic [MAG_W-1:0]  mag_q [LANES];
    logic [MAG_W-1:0]  mag_d [LANES];
    logic [LANES-1:0]  neg_q, neg_d;

    logic [MAG_W-1:0]  mag_in [LANES];
    logic [LANES-1:0]  neg_in;
    logic [Q_W-1:0]    q_lane [LANES];
    logic [LANES-1:0]  sat_lane;
    logic [1:0]        sat_inc;
    logic [ADDR_W-1:0] pair_inc;

    assign mag_in[0] = sspect_data_1;
    assign mag_in[1] = sspect_data_2;
    assign neg_in    = {sspect_minus_2, sspect_minus_1};

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            normalizer_quant_lane u_lane (
                .mag   (mag_q[gi]),
                .neg   (neg_q[gi]),
                .q_out (q_lane[gi]),
                .sat   (sat_lane[gi])
            );
        end
    endgenerate

    assign sat_inc  = {1'b0, sat_lane[0]} + {1'b0, sat_lane[1]};
    assign pair_inc = pair_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        frame_len_d = frame_len_q;
        pair_cnt_d  = pair_cnt_q;
        sat_count_d = sat_count_q;
        data_d      = data_q;
        neg_d       = neg_q;
        for (int i = 0; i < LANES; i++) begin
            mag_d[i] = mag_q[i];
        end

        // A restart wins over whatever the FSM was doing, including a stalled write.
        if (start) begin
            frame_len_d = frame_len;
            pair_cnt_d  = '0;
            sat_count_d = '0;
            state_d     = (frame_len == '0) ? ST_DONE : ST_WAIT_IN;
        end else begin
            case (state_q)
                ST_WAIT_IN: begin
                    if (sspect_valid) begin
                        for (int i = 0; i < LANES; i++) begin
                            mag_d[i] = mag_in[i];
                        end
                        neg_d   = neg_in;
                        state_d = ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    data_d      = {q_lane[0], q_lane[1]};
                    sat_count_d = sat_add(sat_count_q, sat_inc);
                    state_d     = ST_WRITE;
                end
                ST_WRITE: begin
                    if (!mem_busy) begin
                        pair_cnt_d = pair_inc;
                        state_d    = (pair_inc == frame_len_q) ? ST_DONE : ST_WAIT_IN;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            frame_len_q <= '0;
            pair_cnt_q  <= '0;
            sat_count_q <= '0;
            data_q      <= '0;
            neg_q       <= '0;
            for (int i = 0; i < LANES; i++) begin
                mag_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            frame_len_q <= frame_len_d;
            pair_cnt_q  <= pair_cnt_d;
            sat_count_q <= sat_count_d;
            data_q      <= data_d;
            neg_q       <= neg_d;
            for (int i = 0; i < LANES; i++) begin
                mag_q[i] <= mag_d[i];
            end
        end
    end

    // Outputs decode directly from state so reset clears them without a clock edge.
    assign sspect_rdy = (state_q == ST_WAIT_IN) && sspect_valid;
    assign mem_wr     = (state_q == ST_WRITE);
    assign mem_addr   = mem_wr ? pair_cnt_q : '0;
    assign mem_data   = mem_wr ? data_q : '0;
    assign frame_done = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign sat_count  = sat_count_q;

endmodule

// File: tb/tb_normalizer_quantizer.sv
// Self-checking bench for normalizer_quantizer: table of pair vectors plus
// hand-written stall, restart, empty-frame and reset-during-write sequences.
module tb_normalizer_quantizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  frame_len;
    logic [31:0] sspect_data_1, sspect_data_2;
    logic        sspect_minus_1, sspect_minus_2;
    logic        sspect_valid;
    logic        sspect_rdy;
    logic [9:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_wr;
    logic        mem_busy;
    logic        frame_done;
    logic [7:0]  sat_count;
    logic        busy;

    normalizer_quantizer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .frame_len      (frame_len),
        .sspect_data_1  (sspect_data_1),
        .sspect_data_2  (sspect_data_2),
        .sspect_minus_1 (sspect_minus_1),
        .sspect_minus_2 (sspect_minus_2),
        .sspect_valid   (sspect_valid),
        .sspect_rdy     (sspect_rdy),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_wr         (mem_wr),
        .mem_busy       (mem_busy),
        .frame_done     (frame_done),
        .sat_count      (sat_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] m1;
        logic        n1;
        logic [31:0] m2;
        logic        n2;
        logic [15:0] exp_data;
        int          exp_sat;
    } vec_t;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         done_seen = 0;
    logic [9:0] model_addr;
    int         model_sat;

    always @(negedge clk) begin
        if (frame_done) done_seen++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [9:0] len);
        @(posedge clk); #1;
        start      = 1'b1;
        frame_len  = len;
        model_addr = '0;
        model_sat  = 0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_pair(input vec_t v);
        int   waited;
        exp_t e;
        sspect_data_1  = v.m1;
        sspect_minus_1 = v.n1;
        sspect_data_2  = v.m2;
        sspect_minus_2 = v.n2;
        sspect_valid   = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!sspect_rdy && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!sspect_rdy) begin
            tests++;
            fails++;
            $display("FAIL rdy_timeout: got rdy=0 after %0d cycles, required 1", waited);
            sspect_valid = 1'b0;
            return;
        end
        e.addr = model_addr;
        e.data = v.exp_data;
        exp_q.push_back(e);
        model_addr++;
        model_sat = (model_sat + v.exp_sat > 255) ? 255 : model_sat + v.exp_sat;
        @(posedge clk); #1;
        sspect_valid = 1'b0;
    endtask

    task automatic expect_write(input string name, output int lat);
        exp_t e;
        lat = 0;
        @(negedge clk);
        lat = 1;
        while (!(mem_wr && !mem_busy) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!(mem_wr && !mem_busy)) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no write in %0d cycles, required a write", name, lat);
            return;
        end
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_unexpected: got write addr=%0d, required none", name, mem_addr);
            return;
        end
        e = exp_q.pop_front();
        check({name, "_addr"}, 32'(mem_addr), 32'(e.addr));
        check({name, "_data"}, 32'(mem_data), 32'(e.data));
        check({name, "_sat"}, 32'(sat_count), 32'(model_sat));
        $display("[TB] write %s addr=%0d data=0x%04h sat=%0d lat=%0d", name, mem_addr, mem_data, sat_count, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        int   lat;
        int   d0;

        tbl[0] = '{32'h0000_8000, 1'b0, 32'h0000_8000, 1'b1, 16'h40C0, 0};
        tbl[1] = '{32'h0001_0000, 1'b0, 32'h0003_2000, 1'b1, 16'h7F81, 2};
        tbl[2] = '{32'h0000_FF00, 1'b0, 32'h0000_0100, 1'b1, 16'h7FFF, 1};
        tbl[3] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 16'h0000, 0};
        tbl[4] = '{32'h0000_0200, 1'b0, 32'h0000_0300, 1'b1, 16'h01FE, 0};
        tbl[5] = '{32'hFFFF_FFFF, 1'b1, 32'h0000_FE00, 1'b0, 16'h817F, 1};
        tbl[6] = '{32'h0000_7F80, 1'b1, 32'h0000_FEFF, 1'b0, 16'hC07F, 0};
        tbl[7] = '{32'h0001_0000, 1'b1, 32'h0000_FFFF, 1'b1, 16'h8181, 2};

        rst = 1'b0; start = 1'b0; frame_len = '0; mem_busy = 1'b0;
        sspect_data_1 = 32'h0000_8000; sspect_data_2 = 32'h0000_8000;
        sspect_minus_1 = 1'b0; sspect_minus_2 = 1'b0; sspect_valid = 1'b1;
        model_addr = '0; model_sat = 0;

        // Reset state
        #3;
        check("rst_busy", 32'(busy), 0);
        check("rst_rdy", 32'(sspect_rdy), 0);
        check("rst_mem_wr", 32'(mem_wr), 0);
        check("rst_mem_data", 32'(mem_data), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_sat", 32'(sat_count), 0);
        @(negedge clk);
        rst = 1'b1;
        sspect_valid = 1'b0;

        // Single-pair frame: latency and done pulse
        do_start(10'd1);
        send_pair(tbl[0]);
        expect_write("one", lat);
        check("one_latency", 32'(lat), 2);
        @(negedge clk);
        check("one_done", 32'(frame_done), 1);
        @(negedge clk);
        check("one_done_pulse", 32'(frame_done), 0);
        check("one_idle", 32'(busy), 0);

        // IDLE ignores valid input
        sspect_valid = 1'b1;
        @(negedge clk);
        check("idle_rdy", 32'(sspect_rdy), 0);
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        sspect_valid = 1'b0;

        // Empty frame goes straight to DONE
        do_start(10'd0);
        @(negedge clk);
        check("empty_done", 32'(frame_done), 1);
        check("empty_wr", 32'(mem_wr), 0);
        @(negedge clk);
        check("empty_idle", 32'(busy), 0);

        // Table-driven frame of 8 pairs
        do_start(10'd8);
        for (int i = 0; i < 8; i++) begin
            send_pair(tbl[i]);
            expect_write($sformatf("vec%0d", i), lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 2);
        end
        @(negedge clk);
        check("tbl_done", 32'(frame_done), 1);
        check("tbl_sat_total", 32'(sat_count), 6);
        @(negedge clk);
        check("tbl_idle", 32'(busy), 0);
        check("tbl_sat_hold", 32'(sat_count), 6);

        // Write stall: mem_busy high for three WRITE cycles
        do_start(10'd2);
        send_pair(tbl[0]);
        mem_busy = 1'b1;
        sspect_data_1 = tbl[1].m1; sspect_minus_1 = tbl[1].n1;
        sspect_data_2 = tbl[1].m2; sspect_minus_2 = tbl[1].n2;
        sspect_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_wr", k), 32'(mem_wr), 1);
            check($sformatf("stall%0d_data", k), 32'(mem_data), 32'(exp_q[0].data));
            check($sformatf("stall%0d_addr", k), 32'(mem_addr), 0);
            check($sformatf("stall%0d_rdy", k), 32'(sspect_rdy), 0);
        end
        @(posedge clk); #1;
        mem_busy = 1'b0;
        expect_write("stall_a", lat);
        check("stall_a_latency", 32'(lat), 1);
        send_pair(tbl[1]);
        expect_write("stall_b", lat);
        @(negedge clk);
        check("stall_done", 32'(frame_done), 1);

        // Restart mid-frame
        do_start(10'd4);
        send_pair(tbl[0]);
        expect_write("rs_pre0", lat);
        send_pair(tbl[1]);
        expect_write("rs_pre1", lat);
        d0 = done_seen;
        do_start(10'd4);
        for (int i = 2; i < 6; i++) begin
            send_pair(tbl[i]);
            expect_write($sformatf("rs%0d", i - 2), lat);
        end
        @(negedge clk);
        check("rs_done", 32'(frame_done), 1);
        @(posedge clk); #1;
        check("rs_done_count", 32'(done_seen), 32'(d0 + 1));

        // Reset asserted during a stalled write
        do_start(10'd1);
        send_pair(tbl[0]);
        mem_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("arst_pre_wr", 32'(mem_wr), 1);
        #1;
        rst = 1'b0;
        #1;
        check("arst_wr", 32'(mem_wr), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_data", 32'(mem_data), 0);
        check("arst_sat", 32'(sat_count), 0);
        exp_q.delete();
        d0 = done_seen;
        @(negedge clk);
        rst = 1'b1;
        mem_busy = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        check("arst_no_done", 32'(done_seen), 32'(d0));
        check("arst_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
